// File: rtl/alu_pkg.sv
// Shared definitions for the lab-board ALU stages: function encodings and
// the result register reset value.
package alu_pkg;

   localparam logic [2:0] F_INC   = 3'b000;
   localparam logic [2:0] F_ADD   = 3'b001;
   localparam logic [2:0] F_ADDV  = 3'b010;
   localparam logic [2:0] F_ORXOR = 3'b011;
   localparam logic [2:0] F_RED   = 3'b100;
   localparam logic [2:0] F_CAT   = 3'b101;
   localparam logic [2:0] F_MS    = 3'b110;
   localparam logic [2:0] F_HOLD  = 3'b111;

   localparam logic [7:0] Q_RST = 8'h00;

endpackage

// File: rtl/alu_reg_if.sv
// Operand/function/step inputs and result/status outputs of the registered
// ALU stage, bundled with a driver (master) and a DUT (slave) view.
interface alu_reg_if #(
   parameter int CNT_W = 8
) ();

   logic [3:0]       A;
   logic [2:0]       func;
   logic             step;
   logic [7:0]       q;
   logic             carry_sticky;
   logic [CNT_W-1:0] step_cnt;
   logic             upd;

   modport master (
      output A, func, step,
      input  q, carry_sticky, step_cnt, upd
   );

   modport slave (
      input  A, func, step,
      output q, carry_sticky, step_cnt, upd
   );

endinterface

// File: rtl/step_sync.sv
// Two-flop synchronizer plus edge-history flop for an asynchronous step
// level; emits a single-cycle pulse per rising edge of the step input.
module step_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic step_async,
   output logic pulse
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = step_async;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // NOTE: state flops use non-blocking assignments so every stage samples the previous stage's old value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/alu_reg.sv
// Registered accumulator ALU: q[3:0] feeds back as operand B, updated on each
// synchronized step edge. Define ALU_REG_MULT_EN to make func 110 multiply.
module alu_reg
   import alu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   alu_reg_if.slave   bus
);

   logic             pulse;
   logic [3:0]       b;
   logic [4:0]       sum5;
   logic [7:0]       res;
   logic             carry_hit;

   logic [7:0]       result_q, result_d;
   logic             carry_sticky_q, carry_sticky_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             upd_q, upd_d;

   step_sync u_step_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_async (bus.step),
      .pulse      (pulse)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch appears.
   always_comb begin
      b         = result_q[3:0];
      sum5      = 5'b0;
      res       = result_q;
      carry_hit = 1'b0;

      case (bus.func)
         F_INC: begin
            sum5      = {1'b0, bus.A} + 5'd1;
            res       = {3'b0, sum5};
            carry_hit = sum5[4];
         end
         F_ADD, F_ADDV: begin
            sum5      = {1'b0, bus.A} + {1'b0, b};
            res       = {3'b0, sum5};
            carry_hit = sum5[4];
         end
         F_ORXOR: res = {bus.A | b, bus.A ^ b};
         F_RED:   res = {7'b0, |{bus.A, b}};
         F_CAT:   res = {bus.A, b};
         F_MS: begin
`ifdef ALU_REG_MULT_EN
            // One ripple-add row per bit of B, each adding A shifted into place.
            res = 8'h00;
            for (int i = 0; i < 4; i++) begin
               if (b[i]) res = res + ({4'b0, bus.A} << i);
            end
`else
            res = {4'b0, b} << bus.A[2:0];
`endif
         end
         default: res = result_q;
      endcase

      result_d       = pulse ? res : result_q;
      carry_sticky_d = carry_sticky_q | (pulse & carry_hit);
      step_cnt_d     = (pulse && (step_cnt_q != {CNT_W{1'b1}})) ? step_cnt_q + CNT_W'(1)
                                                                 : step_cnt_q;
      upd_d          = pulse;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result_q       <= Q_RST;
         carry_sticky_q <= 1'b0;
         step_cnt_q     <= '0;
         upd_q          <= 1'b0;
      end else begin
         result_q       <= result_d;
         carry_sticky_q <= carry_sticky_d;
         step_cnt_q     <= step_cnt_d;
         upd_q          <= upd_d;
      end
   end

   assign bus.q            = result_q;
   assign bus.carry_sticky = carry_sticky_q;
   assign bus.step_cnt     = step_cnt_q;
   assign bus.upd          = upd_q;

endmodule
